// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch FSM state encoding and instruction size constant
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory read port between fetch_ctrl and the memory
interface fetch_ctrl_if #(
    parameter int WL = 32
) ();
    logic          imem_req;
    logic [WL-1:0] imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch controller with IF/ID register and redirect handling
// Optional stall counter output enabled by FETCH_STALL_CNT_EN.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int            WL      = 32,
    parameter logic [WL-1:0] RST_VEC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [WL-1:0] PC_in,
    input  logic          stall_i,
    input  logic          br_taken,
    input  logic [WL-1:0] br_target,
    input  logic          jmp,
    input  logic [WL-1:0] jmp_target,
    fetch_ctrl_if.master  imem,
    output logic [WL-1:0] PC_next,
    output logic          PC_EN,
    output logic [31:0]   IFID_instr,
    output logic [WL-1:0] IFID_pc4,
    output logic          IFID_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    fetch_state_e  state_q, state_d;
    logic [31:0]   hold_q, hold_d;
    logic [31:0]   ifid_instr_q, ifid_instr_d;
    logic [WL-1:0] ifid_pc4_q, ifid_pc4_d;
    logic          ifid_valid_q, ifid_valid_d;
    logic          req;
    logic          redirect;
    logic [WL-1:0] redirect_tgt;
    logic [WL-1:0] pc_seq;

    assign redirect     = jmp | br_taken;
    assign redirect_tgt = jmp ? jmp_target : br_target;
    assign pc_seq       = PC_in + WL'(INSTR_BYTES);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    state_d = imem.imem_ready ? FETCH : DROP;
                end else if (imem.imem_ready && stall_i) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall_i) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (imem.imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // A redirect always wins over stall and voids whatever is captured or in flight.
    always_comb begin
        req          = 1'b0;
        PC_EN        = 1'b0;
        PC_next      = pc_seq;
        hold_d       = hold_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (RST) begin
            PC_EN   = 1'b1;
            PC_next = RST_VEC;
        end else if (redirect) begin
            req          = (state_q == FETCH);
            PC_EN        = 1'b1;
            PC_next      = redirect_tgt;
            ifid_valid_d = 1'b0;
            hold_d       = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    req = 1'b1;
                    if (imem.imem_ready && !stall_i) begin
                        PC_EN        = 1'b1;
                        ifid_instr_d = imem.imem_rdata;
                        ifid_pc4_d   = pc_seq;
                        ifid_valid_d = 1'b1;
                    end else if (imem.imem_ready) begin
                        hold_d = imem.imem_rdata;
                    end else if (!stall_i) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        PC_EN        = 1'b1;
                        ifid_instr_d = hold_q;
                        ifid_pc4_d   = pc_seq;
                        ifid_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q       <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = PC_in;
    assign IFID_instr     = ifid_instr_q;
    assign IFID_pc4       = ifid_pc4_q;
    assign IFID_valid     = ifid_valid_q;

`ifdef FETCH_STALL_CNT_EN
    sat_counter #(
        .W(32)
    ) u_stall_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .inc_i((state_q == FETCH) && (stall_i || !imem.imem_ready)),
        .cnt_o(stall_cnt)
    );
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam logic [31:0] RVEC = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PC_in = '0;
    logic        stall_i = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = '0;
    logic [31:0] PC_next;
    logic        PC_EN;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc4;
    logic        IFID_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_ctrl_if #(.WL(32)) imem ();

    fetch_ctrl #(.WL(32), .RST_VEC(RVEC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_in     (PC_in),
        .stall_i   (stall_i),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp       (jmp),
        .jmp_target(jmp_target),
        .imem      (imem),
        .PC_next   (PC_next),
        .PC_EN     (PC_EN),
        .IFID_instr(IFID_instr),
        .IFID_pc4  (IFID_pc4),
        .IFID_valid(IFID_valid)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: environment PC register, IF/ID contents, captured word, pending discard.
    logic [31:0] pc;
    logic [31:0] m_instr, m_pc4, m_held_w, m_cnt;
    bit          m_valid, m_held_v, m_drop;
    logic [31:0] last_next, last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid();
        chk("ifid_valid", {31'd0, IFID_valid}, {31'd0, m_valid});
        chk("ifid_instr", IFID_instr, m_instr);
        chk("ifid_pc4", IFID_pc4, m_pc4);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_pc_en", {31'd0, PC_EN}, 32'd1);
        chk("rst_pc_next", PC_next, RVEC);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        @(posedge CLK);
        #1;
        pc = RVEC;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        m_held_v = 1'b0; m_held_w = '0; m_drop = 1'b0; m_cnt = '0;
        check_ifid();
    endtask

    task automatic step(input bit s, input bit r, input bit b, input bit j,
                        input logic [31:0] bt, input logic [31:0] jt);
        bit          redir, e_req, e_en, fetching;
        logic [31:0] tgt, seq;
        @(negedge CLK);
        RST = 1'b0;
        stall_i = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
        imem.imem_ready = r;
        imem.imem_rdata = mem_word(pc);
        PC_in = pc;
        redir    = j | b;
        tgt      = j ? jt : bt;
        seq      = pc + 32'd4;
        fetching = !m_drop && !m_held_v;
        e_req    = fetching;
        e_en     = redir || (!m_drop && !s && (m_held_v || r));
        #1;
        last_next = PC_next;
        last_addr = imem.imem_addr;
        chk("imem_req", {31'd0, imem.imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", imem.imem_addr, pc);
        chk("pc_en", {31'd0, PC_EN}, {31'd0, e_en});
        if (e_en) chk("pc_next", PC_next, redir ? tgt : seq);
        @(posedge CLK);
        #1;
        if (fetching && (s || !r) && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_drop) begin
            if (redir) m_valid = 1'b0;
            if (r) m_drop = 1'b0;
        end else if (m_held_v) begin
            if (redir) begin
                m_valid = 1'b0; m_held_v = 1'b0;
            end else if (!s) begin
                m_instr = m_held_w; m_pc4 = seq; m_valid = 1'b1; m_held_v = 1'b0;
            end
        end else begin
            if (redir) begin
                m_valid = 1'b0; m_drop = !r;
            end else if (r && !s) begin
                m_instr = mem_word(pc); m_pc4 = seq; m_valid = 1'b1;
            end else if (r) begin
                m_held_w = mem_word(pc); m_held_v = 1'b1;
            end else if (!s) begin
                m_valid = 1'b0;
            end
        end
        if (e_en) pc = redir ? tgt : seq;
        check_ifid();
    endtask

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = '0;
        do_reset();

        step(0, 1, 0, 0, 0, 0); chk("seq_104", last_next, 32'h104);
        step(0, 1, 0, 0, 0, 0); chk("seq_108", last_next, 32'h108);
        chk("valid_2nd", {31'd0, IFID_valid}, 32'd1);
        step(0, 1, 0, 0, 0, 0); chk("seq_10c", last_next, 32'h10C);

        step(0, 1, 0, 1, 0, 32'h20);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("hold_instr", IFID_instr, mem_word(32'h20));
        chk("hold_pc4", IFID_pc4, 32'h24);

        step(1, 1, 1, 0, 32'h400, 0); chk("br_stall", last_next, 32'h400);
        chk("br_bubble", {31'd0, IFID_valid}, 32'd0);
        step(0, 1, 1, 1, 32'h400, 32'h800); chk("jmp_prio", last_next, 32'h800);

        step(0, 0, 1, 0, 32'h300, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("drop_discard", {31'd0, IFID_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        chk("drop_resume", last_addr, 32'h300);
        chk("drop_pc4", IFID_pc4, 32'h304);

        step(0, 1, 0, 1, 0, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0); chk("wrap", last_next, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        begin
            logic [31:0] before;
            before = stall_cnt;
            for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
            chk("stall_cnt_5", stall_cnt, before + 32'd5);
        end
`endif

        step(1, 1, 0, 0, 0, 0);
        do_reset();
        step(0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WL, default 32, meaning address/data word length in bits.
REQ-002 SHALL have parameter RST_VEC, default 0, meaning fetch address loaded on reset.
REQ-003 CLK  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 PC_in  in  WL  current PC value from the PC register.
REQ-006 stall_i  in  1  hazard-unit stall request for the IF stage.
REQ-007 br_taken / br_target  in  1 / WL  branch redirect and its target, resolved in ID.
REQ-008 jmp / jmp_target  in  1 / WL  jump redirect and its target.
REQ-009 imem_req / imem_addr  out  1 / WL  instruction-memory read request and its byte address.
REQ-010 imem_ready / imem_rdata  in  1 / 32  read-complete strobe and instruction word.
REQ-011 PC_next / PC_EN  out  WL / 1  next-PC value and load enable driving the PC register.
REQ-012 IFID_instr / IFID_pc4 / IFID_valid  out  32 / WL / 1  IF/ID pipeline register contents.

Function
REQ-013 SHALL implement a 3-state FSM: FETCH (request outstanding), HOLD (instruction captured, downstream stalled), DROP (discarding an in-flight read after redirect).
REQ-014 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC_in.
REQ-015 Sequential next PC SHALL be PC_in + 4, truncated to WL bits (0xFFFFFFFC wraps to 0x00000000).
REQ-016 Redirect priority SHALL be jmp > br_taken > sequential.
REQ-017 FETCH with imem_ready=1, stall_i=0, no redirect: PC_EN=1, PC_next=PC_in+4, IFID_instr<=imem_rdata, IFID_pc4<=PC_in+4, IFID_valid<=1 on the same edge; state stays FETCH (one instruction per cycle, zero-wait memory).
REQ-018 FETCH with imem_ready=1, stall_i=1: instruction SHALL be captured in an internal hold register, PC_EN=0, IFID outputs unchanged, next state HOLD.
REQ-019 HOLD: imem_req=0, PC_EN=0; when stall_i falls, held word SHALL load into IFID with PC_EN=1, PC_next=PC_in+4, next state FETCH.
REQ-020 FETCH with imem_ready=0: PC_EN=0, IFID_valid<=0 (bubble) unless stall_i=1, in which case IFID SHALL hold.
REQ-021 Redirect (jmp or br_taken) in any state SHALL override stall_i: PC_EN=1, PC_next=target, IFID_valid<=0, hold register discarded.
REQ-022 Redirect in FETCH with imem_ready=0 SHALL enter DROP; DROP keeps imem_req=0 and returns to FETCH on the first imem_ready=1, discarding that word.
REQ-023 Redirect in FETCH with imem_ready=1 SHALL discard the returned word and stay in FETCH.
REQ-024 PC_EN and PC_next SHALL be combinational from state and inputs; IFID outputs SHALL be registered.

Reset
REQ-025 RST=1 SHALL asynchronously force state FETCH, IFID_valid=0, IFID_instr=0, IFID_pc4=0, hold register cleared.
REQ-026 During RST, PC_EN=1 and PC_next=RST_VEC, imem_req=0.
REQ-027 RST asserted mid-read SHALL abandon the read; a response arriving after RST deassertion with no new request SHALL be ignored.

Configuration
REQ-028 Macro FETCH_STALL_CNT_EN SHALL, when defined, add output stall_cnt (32 bits, reset 0) incrementing once per cycle that stall_i=1 or imem_ready=0 in FETCH, saturating at 0xFFFFFFFF.
REQ-029 Without FETCH_STALL_CNT_EN, the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 FSM state encoding (FETCH, HOLD, DROP) and constant INSTR_BYTES=4 SHALL live in shared package mips_pkg.
REQ-031 The optional counter SHALL be a sub-module sat_counter; the FSM and IFID register stay in fetch_ctrl.

Verification
REQ-032 Reset with RST_VEC=0x100, then imem_ready=1 constant -> PC_next sequence 0x104, 0x108, 0x10C; IFID_valid=1 from the second edge.
REQ-033 stall_i=1 for 3 cycles while imem_ready=1 at PC 0x20 -> state HOLD, PC_EN=0 for 3 cycles, IFID unchanged; release -> IFID_instr=word@0x20, IFID_pc4=0x24.
REQ-034 br_taken=1, br_target=0x400 with stall_i=1 -> PC_EN=1, PC_next=0x400, IFID_valid=0 next cycle.
REQ-035 jmp=1 (0x800) and br_taken=1 (0x400) together -> PC_next=0x800.
REQ-036 Redirect with imem_ready=0, late ready after 2 cycles -> DROP entered, late word not written to IFID, fetch resumes at the target.
REQ-037 PC_in=0xFFFFFFFC, imem_ready=1 -> PC_next=0x00000000; with FETCH_STALL_CNT_EN, 5 cycles imem_ready=0 -> stall_cnt=5.
